// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, ALU, EX/MEM register and an iterative mult/div unit with HI/LO.
// Optional macro SIGNED_MULDIV_EN: two's-complement mult/div with one extra sign-fix cycle.
module ex_stage_md #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REG_DIR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    readd1,
  input  logic [DATA_WIDTH-1:0]    readd2,
  input  logic [DATA_WIDTH-1:0]    SignExtendOut,
  input  logic [1:0]               Forward_A,
  input  logic [1:0]               Forward_B,
  input  logic [DATA_WIDTH-1:0]    WBData,
  input  logic [DATA_WIDTH-1:0]    Address,
  input  logic                     ALUSrc,
  input  logic                     RegDst,
  input  logic [REG_DIR_WIDTH-1:0] RegDst1,
  input  logic [REG_DIR_WIDTH-1:0] RegDst2,
  input  logic [1:0]               ALUop,
  input  logic [5:0]               funct,
  input  logic                     RegWrite_in,
  output logic                     ex_valid,
  output logic                     ex_wen,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic [REG_DIR_WIDTH-1:0] WriteReg,
  output logic [DATA_WIDTH-1:0]    StoreData,
  output logic                     Ov,
  output logic                     stall
);
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MULT, OP_DIV
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  op_t           op;
  state_t        state, state_nxt;
  logic [DW-1:0] fwd_a, fwd_b, alu_b, alu_res, sum, diff;
  logic          alu_ov, is_md, uses_hilo, accept, md_start;
  logic [DW-1:0] hi, lo, md_hi, md_lo, md_b, a_mag, b_mag;
  logic [DW-1:0] step_hi, step_lo, div_hi, div_lo;
  logic [DW:0]   mul_sum, div_sh;
  logic          div_ge;
  logic [CNT_WIDTH-1:0] cnt;

  // Opcode / funct decode
  always_comb begin
    op = OP_ADD;
    case (ALUop)
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      2'b10: begin
        case (funct)
          6'h22:   op = OP_SUB;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h2A:   op = OP_SLT;
          6'h10:   op = OP_MFHI;
          6'h12:   op = OP_MFLO;
          6'h18:   op = OP_MULT;
          6'h1A:   op = OP_DIV;
          default: op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  // Operand forwarding
  always_comb begin
    case (Forward_A)
      2'd0:    fwd_a = readd1;
      2'd1:    fwd_a = WBData;
      2'd2:    fwd_a = Address;
      default: fwd_a = '0;
    endcase
    case (Forward_B)
      2'd0:    fwd_b = readd2;
      2'd1:    fwd_b = WBData;
      2'd2:    fwd_b = Address;
      default: fwd_b = '0;
    endcase
  end

  assign alu_b = ALUSrc ? SignExtendOut : fwd_b;
  assign sum   = fwd_a + alu_b;
  assign diff  = fwd_a - alu_b;

  always_comb begin
    alu_res = sum;
    alu_ov  = 1'b0;
    case (op)
      OP_ADD:  alu_ov = (fwd_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != fwd_a[DW-1]);
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (fwd_a[DW-1] != alu_b[DW-1]) && (diff[DW-1] != fwd_a[DW-1]);
      end
      OP_AND:  alu_res = fwd_a & alu_b;
      OP_OR:   alu_res = fwd_a | alu_b;
      OP_SLT:  alu_res = DW'($signed(fwd_a) < $signed(alu_b));
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = sum;
    endcase
  end

  assign is_md     = (op == OP_MULT) || (op == OP_DIV);
  assign uses_hilo = is_md || (op == OP_MFHI) || (op == OP_MFLO);
  assign stall     = (state != S_IDLE) && in_valid && uses_hilo;
  assign accept    = in_valid && !stall;
  assign md_start  = accept && is_md;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (md_start) state_nxt = (op == OP_DIV) ? S_DIV : S_MUL;
      S_MUL, S_DIV: begin
        if (cnt == CNT_WIDTH'(DW - 1)) begin
`ifdef SIGNED_MULDIV_EN
          state_nxt = S_FIX;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration: shift-add multiply or restoring shift-subtract divide
  assign mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_sh  = {md_hi, md_lo[DW-1]};
  assign div_ge  = div_sh >= {1'b0, md_b};
  assign div_hi  = div_ge ? (div_sh[DW-1:0] - md_b) : div_sh[DW-1:0];
  assign div_lo  = {md_lo[DW-2:0], div_ge};
  assign step_hi = (state == S_DIV) ? div_hi : mul_sum[DW:1];
  assign step_lo = (state == S_DIV) ? div_lo : {mul_sum[0], md_lo[DW-1:1]};

`ifdef SIGNED_MULDIV_EN
  logic          neg_a, neg_b, md_div;
  logic [DW-1:0] fix_hi, fix_lo;

  assign a_mag = fwd_a[DW-1] ? -fwd_a : fwd_a;
  assign b_mag = fwd_b[DW-1] ? -fwd_b : fwd_b;

  // Sign fix-up; remainder follows the dividend, divide-by-zero keeps all-ones quotient
  always_comb begin
    fix_hi = md_hi;
    fix_lo = md_lo;
    if (!md_div) begin
      if (neg_a ^ neg_b) {fix_hi, fix_lo} = -{md_hi, md_lo};
    end else begin
      if (neg_a) fix_hi = -md_hi;
      if ((neg_a ^ neg_b) && (md_b != '0)) fix_lo = -md_lo;
    end
  end
`else
  assign a_mag = fwd_a;
  assign b_mag = fwd_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      md_hi <= '0;
      md_lo <= '0;
      md_b  <= '0;
      cnt   <= '0;
`ifdef SIGNED_MULDIV_EN
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      md_div <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start) begin
            cnt   <= '0;
            md_hi <= '0;
            md_lo <= a_mag;
            md_b  <= b_mag;
`ifdef SIGNED_MULDIV_EN
            neg_a  <= fwd_a[DW-1];
            neg_b  <= fwd_b[DW-1];
            md_div <= (op == OP_DIV);
`endif
          end
        end
        S_MUL, S_DIV: begin
          cnt   <= cnt + CNT_WIDTH'(1);
          md_hi <= step_hi;
          md_lo <= step_lo;
`ifndef SIGNED_MULDIV_EN
          if (cnt == CNT_WIDTH'(DW - 1)) begin
            hi <= step_hi;
            lo <= step_lo;
          end
`endif
        end
        default: begin
`ifdef SIGNED_MULDIV_EN
          hi <= fix_hi;
          lo <= fix_lo;
`endif
        end
      endcase
    end
  end

  // EX/MEM register; mult/div and non-accepted cycles become bubbles
  always_ff @(posedge clk) begin
    if (reset || !accept || is_md) begin
      ex_valid  <= 1'b0;
      ex_wen    <= 1'b0;
      ALUResult <= '0;
      WriteReg  <= '0;
      StoreData <= '0;
      Ov        <= 1'b0;
    end else begin
      ex_valid  <= 1'b1;
      ex_wen    <= RegWrite_in;
      ALUResult <= alu_res;
      WriteReg  <= RegDst ? RegDst1 : RegDst2;
      StoreData <= fwd_b;
      Ov        <= alu_ov;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: arithmetic reference model checked every cycle plus directed literal checks.
module tb_ex_stage_md;
  localparam int DW = 8;
`ifdef SIGNED_MULDIV_EN
  localparam int MD_CYC = 9;
`else
  localparam int MD_CYC = 8;
`endif

  logic clk, reset, in_valid, ALUSrc, RegDst, RegWrite_in;
  logic [7:0] readd1, readd2, SignExtendOut, WBData, Address;
  logic [1:0] Forward_A, Forward_B, ALUop;
  logic [2:0] RegDst1, RegDst2;
  logic [5:0] funct;
  logic ex_valid, ex_wen, Ov, stall;
  logic [7:0] ALUResult, StoreData;
  logic [2:0] WriteReg;

  ex_stage_md #(.DATA_WIDTH(8), .REG_DIR_WIDTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .readd1(readd1), .readd2(readd2),
    .SignExtendOut(SignExtendOut), .Forward_A(Forward_A), .Forward_B(Forward_B),
    .WBData(WBData), .Address(Address), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .RegDst1(RegDst1), .RegDst2(RegDst2), .ALUop(ALUop), .funct(funct),
    .RegWrite_in(RegWrite_in), .ex_valid(ex_valid), .ex_wen(ex_wen),
    .ALUResult(ALUResult), .WriteReg(WriteReg), .StoreData(StoreData), .Ov(Ov),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // reference model state
  int m_busy = 0;
  logic [7:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  logic e_valid = 0, e_wen = 0, e_ov = 0;
  logic [7:0] e_res = 0, e_sd = 0;
  logic [2:0] e_wreg = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // 0 add,1 sub,2 and,3 or,4 slt,5 mfhi,6 mflo,7 mult,8 div
  function automatic int kind_of(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 0;
    if (op == 2'b01) return 1;
    if (op == 2'b11) return 3;
    case (fn)
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2A: return 4;
      6'h10: return 5;
      6'h12: return 6;
      6'h18: return 7;
      6'h1A: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] fwd(input logic [1:0] sel, input logic [7:0] rd);
    case (sel)
      2'd0: return rd;
      2'd1: return WBData;
      2'd2: return Address;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_stall();
    return in_valid && (m_busy > 0) && (kind_of(ALUop, funct) >= 5);
  endfunction

  task automatic model_update();
    int k, sa, sb, s;
    logic [7:0] a, bq, b;
    logic [15:0] p;
    logic acc;
    if (reset) begin
      m_busy = 0; m_hi = 0; m_lo = 0;
      e_valid = 0; e_wen = 0; e_ov = 0; e_res = 0; e_sd = 0; e_wreg = 0;
      return;
    end
    k  = kind_of(ALUop, funct);
    a  = fwd(Forward_A, readd1);
    bq = fwd(Forward_B, readd2);
    b  = ALUSrc ? SignExtendOut : bq;
    acc = in_valid && !model_stall();
    e_valid = 0; e_wen = 0; e_ov = 0; e_res = 0; e_sd = 0; e_wreg = 0;
    if (acc && k < 7) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      e_valid = 1;
      e_wen   = RegWrite_in;
      e_wreg  = RegDst ? RegDst1 : RegDst2;
      e_sd    = bq;
      case (k)
        0: begin s = sa + sb; e_res = a + b; e_ov = (s > 127) || (s < -128); end
        1: begin s = sa - sb; e_res = a - b; e_ov = (s > 127) || (s < -128); end
        2: e_res = a & b;
        3: e_res = a | b;
        4: e_res = (sa < sb) ? 8'd1 : 8'd0;
        5: e_res = m_hi;
        default: e_res = m_lo;
      endcase
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end
    if (acc && k >= 7) begin
      m_busy = MD_CYC;
`ifdef SIGNED_MULDIV_EN
      sa = int'($signed(a));
      sb = int'($signed(bq));
`else
      sa = int'(a);
      sb = int'(bq);
`endif
      if (k == 7) begin
        p = 16'(sa * sb);
        m_phi = p[15:8];
        m_plo = p[7:0];
      end else if (bq == 8'h00) begin
        m_plo = 8'hFF;
        m_phi = a;
      end else begin
        m_plo = 8'(sa / sb);
        m_phi = 8'(sa % sb);
      end
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("ex_valid", ex_valid, e_valid);
      chk("ex_wen", ex_wen, e_wen);
      chk("Ov", Ov, e_ov);
      chk("stall", stall, model_stall());
      if (e_valid) begin
        chk("ALUResult", ALUResult, e_res);
        chk("WriteReg", WriteReg, e_wreg);
        chk("StoreData", StoreData, e_sd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    started = 1;
    #1;
  endtask

  task automatic set_nop();
    in_valid = 0; readd1 = 0; readd2 = 0; SignExtendOut = 0; WBData = 0; Address = 0;
    Forward_A = 0; Forward_B = 0; ALUSrc = 0; RegDst = 1; RegDst1 = 3'd5; RegDst2 = 3'd2;
    ALUop = 0; funct = 0; RegWrite_in = 1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [7:0] r1, input logic [7:0] r2);
    set_nop();
    in_valid = 1; ALUop = op; funct = fn; readd1 = r1; readd2 = r2;
  endtask

  // hold fn (mfhi/mflo) until the unit frees, counting stalled cycles
  task automatic wait_md(input logic [5:0] fn, output int cnt);
    set_op(2'b10, fn, 8'h00, 8'h00);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (!stall) break;
      cnt++;
      tick();
    end
  endtask

  typedef struct {
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
  } vec_t;

  initial begin
    int n;
    vec_t vt[6];
    vt[0] = '{6'h24, 8'hF0, 8'h3C, 8'h30};
    vt[1] = '{6'h25, 8'hF0, 8'h0F, 8'hFF};
    vt[2] = '{6'h2A, 8'h80, 8'h01, 8'h01};
    vt[3] = '{6'h2A, 8'h01, 8'h80, 8'h00};
    vt[4] = '{6'h22, 8'h05, 8'h07, 8'hFE};
    vt[5] = '{6'h3F, 8'h12, 8'h34, 8'h46};

    set_nop();
    reset = 1;
    tick();
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_res", ALUResult, 0);
    chk("rst_stall", stall, 0);
    reset = 0;

    set_op(2'b00, 6'h00, 8'h7F, 8'h01);
    tick();
    chk("add_res", ALUResult, 8'h80);
    chk("add_ov", Ov, 1);
    chk("add_valid", ex_valid, 1);

    set_op(2'b01, 6'h00, 8'h00, 8'h05);
    Forward_A = 2; Address = 8'h10;
    tick();
    chk("sub_fwd_res", ALUResult, 8'h0B);
    chk("sub_fwd_ov", Ov, 0);

    foreach (vt[i]) begin
      set_op(2'b10, vt[i].fn, vt[i].a, vt[i].b);
      tick();
      chk("rtype_res", ALUResult, vt[i].r);
    end

    set_op(2'b00, 6'h00, 8'h77, 8'h00);
    Forward_A = 3; Forward_B = 1; WBData = 8'h21; RegDst = 0;
    tick();
    chk("fwd_zero_wb", ALUResult, 8'h21);
    chk("fwd_wreg", WriteReg, 3'd2);

    set_op(2'b00, 6'h00, 8'h10, 8'h99);
    ALUSrc = 1; SignExtendOut = 8'h04; RegWrite_in = 0;
    tick();
    chk("imm_res", ALUResult, 8'h14);
    chk("imm_store", StoreData, 8'h99);
    chk("imm_wen", ex_wen, 0);

    set_nop();
    tick();
    chk("bubble_valid", ex_valid, 0);

    // mult 13*11 followed by mflo / mfhi
    set_op(2'b10, 6'h18, 8'd13, 8'd11);
    tick();
    chk("mult_bubble", ex_valid, 0);
    wait_md(6'h12, n);
    chk("mult_stall_cycles", n, MD_CYC);
    tick();
    chk("mult_lo", ALUResult, 8'h8F);
    set_op(2'b10, 6'h10, 8'h00, 8'h00);
    tick();
    chk("mult_hi", ALUResult, 8'h00);

    // div 100/7 with an independent or during busy
    set_op(2'b10, 6'h1A, 8'd100, 8'd7);
    tick();
    set_op(2'b11, 6'h00, 8'h50, 8'h0A);
    #2;
    chk("or_no_stall", stall, 0);
    tick();
    chk("or_res", ALUResult, 8'h5A);
    chk("or_valid", ex_valid, 1);
    wait_md(6'h12, n);
    chk("div_stall_cycles", n, MD_CYC - 1);
    tick();
    chk("div_lo", ALUResult, 8'h0E);
    set_op(2'b10, 6'h10, 8'h00, 8'h00);
    tick();
    chk("div_hi", ALUResult, 8'h02);

    // divide by zero
    set_op(2'b10, 6'h1A, 8'h55, 8'h00);
    tick();
    wait_md(6'h12, n);
    tick();
    chk("div0_lo", ALUResult, 8'hFF);
    set_op(2'b10, 6'h10, 8'h00, 8'h00);
    tick();
    chk("div0_hi", ALUResult, 8'h55);

    // 0xFD * 0x04 (signed: -12, unsigned: 1012)
    set_op(2'b10, 6'h18, 8'hFD, 8'h04);
    tick();
    wait_md(6'h10, n);
    chk("mulfd_stall_cycles", n, MD_CYC);
    tick();
`ifdef SIGNED_MULDIV_EN
    chk("mulfd_hi", ALUResult, 8'hFF);
`else
    chk("mulfd_hi", ALUResult, 8'h03);
`endif
    set_op(2'b10, 6'h12, 8'h00, 8'h00);
    tick();
    chk("mulfd_lo", ALUResult, 8'hF4);

    // reset in the middle of a multiply
    set_op(2'b10, 6'h18, 8'd9, 8'd9);
    tick();
    set_op(2'b10, 6'h12, 8'h00, 8'h00);
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    #2;
    chk("rstmid_stall", stall, 0);
    chk("rstmid_valid", ex_valid, 0);
    chk("rstmid_res", ALUResult, 0);
    chk("rstmid_wen", ex_wen, 0);
    tick();
    chk("rstmid_lo", ALUResult, 8'h00);
    chk("rstmid_lo_valid", ex_valid, 1);
    set_op(2'b10, 6'h10, 8'h00, 8'h00);
    tick();
    chk("rstmid_hi", ALUResult, 8'h00);

    set_nop();
    tick();
    tick();
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
